ram_arbiter: RTL and testbench

- Shares one single-port RAM instance between two requesters: port A (host/UART loader) and port B (miner core).
- Each requester uses a req/done handshake. The block arbitrates round-robin, drives the RAM's wEn/addr/dataIn from registers, and returns read data.
- Sits between the loader, the hash core and the nonce/work RAM.
- The RAM acts on the falling clock edge. Its dataOut updates only on reads and holds its value during writes.

---
 rtl/ram_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between requester A (host/UART
// loader) and requester B (miner core) using round-robin arbitration.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   a_req/a_wEn/a_addr/a_dataIn   port A request, held until a_done
//   a_dataOut/a_done        port A read data (valid from a_done) and done pulse
//   b_*                     same as port A, for port B
//   ram_wEn/ram_addr/ram_dataIn   registered drive to the RAM
//   ram_dataOut             RAM read data (RAM acts on falling edge)
//   busy                    high whenever the FSM is not idle
module ram_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_req,
  input  logic                     a_wEn,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_dataIn,
  output logic [DATA_WIDTH-1:0]    a_dataOut,
  output logic                     a_done,
  input  logic                     b_req,
  input  logic                     b_wEn,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]    b_dataIn,
  output logic [DATA_WIDTH-1:0]    b_dataOut,
  output logic                     b_done,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_dataIn,
  input  logic [DATA_WIDTH-1:0]    ram_dataOut,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;

  state_t                   state, state_d;
  port_t                    last_grant, last_grant_d;
  port_t                    sel, sel_d;
  logic                     ram_wEn_d;
  logic [ADDRESS_WIDTH-1:0] ram_addr_d;
  logic [DATA_WIDTH-1:0]    ram_dataIn_d;
  logic [DATA_WIDTH-1:0]    a_dataOut_d, b_dataOut_d;
  logic                     a_done_d, b_done_d;
  logic                     busy_d;
  logic                     grant_a, grant_b;

  // A wins when alone or on a tie if B was the last tie winner; B symmetric
  assign grant_a = a_req && (!b_req || (last_grant == PORT_B));
  assign grant_b = b_req && (!a_req || (last_grant == PORT_A));

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_B;
      sel        <= PORT_A;
      ram_wEn    <= 1'b0;
      ram_addr   <= '0;
      ram_dataIn <= '0;
      a_dataOut  <= '0;
      b_dataOut  <= '0;
      a_done     <= 1'b0;
      b_done     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      sel        <= sel_d;
      ram_wEn    <= ram_wEn_d;
      ram_addr   <= ram_addr_d;
      ram_dataIn <= ram_dataIn_d;
      a_dataOut  <= a_dataOut_d;
      b_dataOut  <= b_dataOut_d;
      a_done     <= a_done_d;
      b_done     <= b_done_d;
      busy       <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    sel_d        = sel;
    ram_wEn_d    = 1'b0;
    ram_addr_d   = ram_addr;
    ram_dataIn_d = ram_dataIn;
    a_dataOut_d  = a_dataOut;
    b_dataOut_d  = b_dataOut;
    a_done_d     = 1'b0;
    b_done_d     = 1'b0;

    case (state)
      IDLE: begin
        if (grant_a) begin
          ram_wEn_d    = a_wEn;
          ram_addr_d   = a_addr;
          ram_dataIn_d = a_dataIn;
          sel_d        = PORT_A;
          state_d      = ACCESS;
          if (b_req) last_grant_d = PORT_A;
        end else if (grant_b) begin
          ram_wEn_d    = b_wEn;
          ram_addr_d   = b_addr;
          ram_dataIn_d = b_dataIn;
          sel_d        = PORT_B;
          state_d      = ACCESS;
          if (a_req) last_grant_d = PORT_B;
        end
      end
      ACCESS: begin
        // RAM completed the operation on the falling edge of this cycle
        if (sel == PORT_A) begin
          if (!ram_wEn) a_dataOut_d = ram_dataOut;
          a_done_d = 1'b1;
        end else begin
          if (!ram_wEn) b_dataOut_d = ram_dataOut;
          b_done_d = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter with a falling-edge RAM model.
module tb_ram_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_wEn, b_req, b_wEn;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_dataIn, b_dataIn;
  logic [DW-1:0] a_dataOut, b_dataOut;
  logic          a_done, b_done;
  logic          ram_wEn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dataIn;
  logic [DW-1:0] ram_dataOut;
  logic          busy;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  ram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_wEn(a_wEn), .a_addr(a_addr), .a_dataIn(a_dataIn),
    .a_dataOut(a_dataOut), .a_done(a_done),
    .b_req(b_req), .b_wEn(b_wEn), .b_addr(b_addr), .b_dataIn(b_dataIn),
    .b_dataOut(b_dataOut), .b_done(b_done),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
    .ram_dataOut(ram_dataOut), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM acts on the falling edge; dataOut only changes on reads
  always @(negedge clk) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    else         ram_dataOut   <= mem[ram_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one request, waits (bounded) for its done, then releases it
  task automatic access(input logic port_b, input logic wen,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic got;
    if (port_b) begin
      b_req = 1'b1; b_wEn = wen; b_addr = addr; b_dataIn = data;
    end else begin
      a_req = 1'b1; a_wEn = wen; a_addr = addr; a_dataIn = data;
    end
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      got = port_b ? b_done : a_done;
    end
    checks++;
    if (got !== 1'b1) begin
      failures++;
      $display("FAIL access_timeout port_b=%0b addr=%h got_done=%b exp=1", port_b, addr, got);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    a_req = 1'b0; a_wEn = 1'b0; a_addr = '0; a_dataIn = '0;
    b_req = 1'b0; b_wEn = 1'b0; b_addr = '0; b_dataIn = '0;
    tick(); tick();
    checks++;
    if ({a_done, b_done, busy, ram_wEn} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {a_done, b_done, busy, ram_wEn});
    end
    checks++;
    if ({a_dataOut, b_dataOut} !== 64'h0) begin
      failures++;
      $display("FAIL reset_dataout got=%h exp=0", {a_dataOut, b_dataOut});
    end
    checks++;
    if ({ram_addr, ram_dataIn} !== 44'h0) begin
      failures++;
      $display("FAIL reset_ram_bus got=%h exp=0", {ram_addr, ram_dataIn});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_a_write;
    a_req = 1'b1; a_wEn = 1'b1; a_addr = 12'h010; a_dataIn = 32'hDEADBEEF;
    tick();
    checks++;
    if ({ram_wEn, busy, a_done} !== 3'b110 || ram_addr !== 12'h010 || ram_dataIn !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL a_write_access got wen/busy/done=%b addr=%h din=%h exp 110 010 deadbeef",
               {ram_wEn, busy, a_done}, ram_addr, ram_dataIn);
    end
    tick();
    checks++;
    if ({a_done, b_done, ram_wEn, busy} !== 4'b1001) begin
      failures++;
      $display("FAIL a_write_done got=%b exp=1001", {a_done, b_done, ram_wEn, busy});
    end
    a_req = 1'b0;
    tick();
    checks++;
    if ({a_done, busy} !== 2'b00 || mem[12'h010] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL a_write_end got done/busy=%b mem=%h exp 00 deadbeef", {a_done, busy}, mem[12'h010]);
    end
  endtask

  task automatic test_a_read;
    a_req = 1'b1; a_wEn = 1'b0; a_addr = 12'h010;
    tick();
    checks++;
    if (ram_wEn !== 1'b0 || ram_addr !== 12'h010 || busy !== 1'b1) begin
      failures++;
      $display("FAIL a_read_access got wen=%b addr=%h busy=%b exp 0 010 1", ram_wEn, ram_addr, busy);
    end
    tick();
    checks++;
    if (a_done !== 1'b1 || a_dataOut !== 32'hDEADBEEF || b_dataOut !== 32'h0) begin
      failures++;
      $display("FAIL a_read_data got done=%b a=%h b=%h exp 1 deadbeef 0", a_done, a_dataOut, b_dataOut);
    end
    a_req = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous;
    access(1'b0, 1'b1, 12'h001, 32'h11111111);
    access(1'b1, 1'b1, 12'h002, 32'h22222222);
    reset = 1'b1; tick(); reset = 1'b0;
    // Round 1: A wins the first tie after reset
    a_req = 1'b1; a_wEn = 1'b0; a_addr = 12'h001;
    b_req = 1'b1; b_wEn = 1'b0; b_addr = 12'h002;
    tick();
    checks++;
    if (ram_addr !== 12'h001) begin
      failures++;
      $display("FAIL tie1_grant got addr=%h exp=001", ram_addr);
    end
    tick();
    checks++;
    if ({a_done, b_done} !== 2'b10 || a_dataOut !== 32'h11111111) begin
      failures++;
      $display("FAIL tie1_a_done got done=%b a=%h exp 10 11111111", {a_done, b_done}, a_dataOut);
    end
    a_req = 1'b0;
    tick();
    checks++;
    if ({busy, a_done, b_done} !== 3'b000) begin
      failures++;
      $display("FAIL tie1_idle got=%b exp=000", {busy, a_done, b_done});
    end
    tick();
    checks++;
    if (ram_addr !== 12'h002 || busy !== 1'b1) begin
      failures++;
      $display("FAIL tie1_b_grant got addr=%h busy=%b exp 002 1", ram_addr, busy);
    end
    tick();
    checks++;
    if ({a_done, b_done} !== 2'b01 || b_dataOut !== 32'h22222222) begin
      failures++;
      $display("FAIL tie1_b_done got done=%b b=%h exp 01 22222222", {a_done, b_done}, b_dataOut);
    end
    b_req = 1'b0;
    tick();
    // Round 2: B wins since A took the previous tie
    a_req = 1'b1; b_req = 1'b1;
    tick();
    checks++;
    if (ram_addr !== 12'h002) begin
      failures++;
      $display("FAIL tie2_grant got addr=%h exp=002", ram_addr);
    end
    tick();
    checks++;
    if ({a_done, b_done} !== 2'b01) begin
      failures++;
      $display("FAIL tie2_b_done got=%b exp=01", {a_done, b_done});
    end
    b_req = 1'b0;
    tick(); tick();
    checks++;
    if (ram_addr !== 12'h001) begin
      failures++;
      $display("FAIL tie2_a_grant got addr=%h exp=001", ram_addr);
    end
    tick();
    checks++;
    if (a_done !== 1'b1) begin
      failures++;
      $display("FAIL tie2_a_done got=%b exp=1", a_done);
    end
    a_req = 1'b0;
    tick();
  endtask

  task automatic test_alternate;
    int n;
    int last_cyc;
    logic exp_b;
    access(1'b0, 1'b1, 12'h003, 32'h33333333);
    a_req = 1'b1; a_wEn = 1'b0; a_addr = 12'h003;
    b_req = 1'b1; b_wEn = 1'b0; b_addr = 12'h002;
    n = 0; last_cyc = 0; exp_b = 1'b0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      tick();
      if (a_done && b_done) begin
        checks++; failures++;
        $display("FAIL alt_both_done cyc=%0d got=11 exp=one", cyc);
      end
      if (a_done || b_done) begin
        checks++;
        if (b_done !== exp_b) begin
          failures++;
          $display("FAIL alt_order n=%0d got_b=%b exp_b=%b", n, b_done, exp_b);
        end
        if (n > 0) begin
          checks++;
          if (cyc - last_cyc > 6) begin
            failures++;
            $display("FAIL alt_gap n=%0d got=%0d exp<=6", n, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        exp_b = ~exp_b;
        n++;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL alt_count got=%0d exp=8", n);
    end
    checks++;
    if (a_dataOut !== 32'h33333333 || b_dataOut !== 32'h22222222) begin
      failures++;
      $display("FAIL alt_data got a=%h b=%h exp 33333333 22222222", a_dataOut, b_dataOut);
    end
  endtask

  task automatic test_b_top;
    b_req = 1'b1; b_wEn = 1'b1; b_addr = 12'hFFF; b_dataIn = 32'hCAFEF00D;
    tick();
    checks++;
    if (ram_addr !== 12'hFFF || ram_wEn !== 1'b1) begin
      failures++;
      $display("FAIL b_top_access got addr=%h wen=%b exp fff 1", ram_addr, ram_wEn);
    end
    tick();
    checks++;
    if (b_done !== 1'b1 || b_dataOut !== 32'h22222222) begin
      failures++;
      $display("FAIL b_top_write_done got done=%b b=%h exp 1 22222222", b_done, b_dataOut);
    end
    b_req = 1'b0;
    tick();
    checks++;
    if (mem[12'hFFF] !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL b_top_mem got=%h exp=cafef00d", mem[12'hFFF]);
    end
    access(1'b1, 1'b0, 12'hFFF, 32'h0);
    checks++;
    if (b_dataOut !== 32'hCAFEF00D || a_dataOut !== 32'h33333333) begin
      failures++;
      $display("FAIL b_top_read got b=%h a=%h exp cafef00d 33333333", b_dataOut, a_dataOut);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    a_req = 1'b1; a_wEn = 1'b0; a_addr = 12'h010;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_access got busy=%b exp=1", busy);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({busy, ram_wEn, a_done} !== 3'b000 || a_dataOut !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_state got=%b a=%h exp 000 0", {busy, ram_wEn, a_done}, a_dataOut);
    end
    reset = 1'b0;
    a_req = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a_done) pulses++;
    end
    checks++;
    if (pulses != 0 || a_dataOut !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_no_done got pulses=%0d a=%h exp 0 0", pulses, a_dataOut);
    end
  endtask

  initial begin
    test_reset();
    test_a_write();
    test_a_read();
    test_simultaneous();
    test_alternate();
    test_b_top();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
